// File: rtl/idst7_mul_arbiter.sv
// idst7_mul_arbiter: round-robin arbiter sharing one pipelined
// 7-bit unsigned x 32-bit signed multiplier among N_REQ requesters.
//
// Ports:
//   clk, reset           clock; synchronous active-high reset
//   req_valid/req_ready  per-requester handshake (ready one-hot or zero)
//   req_coef, req_data   packed operands, requester i at slice i
//   rsp_valid/rsp_ready  result handshake
//   rsp_id, rsp_data     owning requester and low DATA_W product bits
//   stat_ops, stat_stalls  only when IDST7_MUL_ARB_STATS_EN is defined
module idst7_mul_arbiter #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int MUL_LAT = 1,
   parameter int COEF_W  = 7,
   parameter int DATA_W  = 32
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*COEF_W-1:0]  req_coef,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic [DATA_W-1:0]        rsp_data
`ifdef IDST7_MUL_ARB_STATS_EN
   ,
   output logic [31:0]              stat_ops,
   output logic [31:0]              stat_stalls
`endif
);

   localparam int PW = DATA_W + COEF_W + 1;

   logic [ID_W-1:0]     rr_ptr;
   logic [ID_W-1:0]     gnt;
   logic [ID_W-1:0]     nxt_ptr;
   logic [ID_W:0]       sum;
   logic [2*N_REQ-1:0]  dbl;
   logic [N_REQ-1:0]    rot;
   logic                found;
   logic                adv;
   logic                xfer;
   logic [COEF_W-1:0]   coef;
   logic [DATA_W-1:0]   data;
   logic signed [PW-1:0] prod;

   logic [MUL_LAT-1:0]  vld;
   logic [ID_W-1:0]     tag [MUL_LAT];
   logic [DATA_W-1:0]   dat [MUL_LAT];

   // Whole pipe, including the multiplier, moves only when the
   // output slot is free or being drained.
   assign adv  = !rsp_valid || rsp_ready;
   assign xfer = adv && (|req_valid) && !reset;

   // Rotate so bit 0 is the requester at rr_ptr; the first set bit
   // is the grant offset, mapped back with an explicit wrap compare.
   assign dbl = {req_valid, req_valid};
   assign rot = dbl[rr_ptr +: N_REQ];

   always_comb begin
      gnt   = rr_ptr;
      found = 1'b0;
      sum   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            sum   = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(N_REQ))
               sum = sum - (ID_W+1)'(N_REQ);
            gnt = sum[ID_W-1:0];
         end
      end
   end

   assign nxt_ptr = (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + 1'b1;

   always_comb begin
      req_ready = '0;
      if (xfer)
         req_ready = N_REQ'(1) << gnt;
   end

   always_comb begin
      coef = '0;
      data = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (gnt == ID_W'(k)) begin
            coef = req_coef[k*COEF_W +: COEF_W];
            data = req_data[k*DATA_W +: DATA_W];
         end
      end
   end

   // Coefficient is unsigned: zero-extend before the signed multiply.
   assign prod = $signed({1'b0, coef}) * $signed(data);

   always_ff @(posedge clk) begin
      if (reset) begin
         vld    <= '0;
         rr_ptr <= '0;
         for (int k = 0; k < MUL_LAT; k++) begin
            tag[k] <= '0;
            dat[k] <= '0;
         end
      end else if (adv) begin
         vld[0] <= xfer;
         tag[0] <= gnt;
         dat[0] <= prod[DATA_W-1:0];
         for (int k = 1; k < MUL_LAT; k++) begin
            vld[k] <= vld[k-1];
            tag[k] <= tag[k-1];
            dat[k] <= dat[k-1];
         end
         if (xfer)
            rr_ptr <= nxt_ptr;
      end
   end

   assign rsp_valid = vld[MUL_LAT-1];
   assign rsp_id    = tag[MUL_LAT-1];
   assign rsp_data  = dat[MUL_LAT-1];

`ifdef IDST7_MUL_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_ops    <= '0;
         stat_stalls <= '0;
      end else begin
         if (xfer)
            stat_ops <= stat_ops + 32'd1;
         if (rsp_valid && !rsp_ready)
            stat_stalls <= stat_stalls + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_idst7_mul_arbiter.sv
// tb_idst7_mul_arbiter: scoreboard bench for idst7_mul_arbiter,
// one instance with MUL_LAT=1 and one with MUL_LAT=3.
module tb_idst7_mul_arbiter;

   typedef struct packed {
      logic [1:0]  id;
      logic [31:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req_valid;
   logic [27:0] req_coef;
   logic [127:0] req_data;
   logic        rsp_ready;

   logic [3:0]  req_ready,  req_ready3;
   logic        rsp_valid,  rsp_valid3;
   logic [1:0]  rsp_id,     rsp_id3;
   logic [31:0] rsp_data,   rsp_data3;
`ifdef IDST7_MUL_ARB_STATS_EN
   logic [31:0] stat_ops,  stat_stalls;
   logic [31:0] stat_ops3, stat_stalls3;
`endif

   int checks   = 0;
   int failures = 0;
   int rsp_cnt1 = 0;
   exp_t q1[$];
   exp_t q3[$];
   exp_t e1, e3;

   always #5 clk = ~clk;

   idst7_mul_arbiter #(.N_REQ(4), .ID_W(2), .MUL_LAT(1)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_coef(req_coef), .req_data(req_data),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_data(rsp_data)
`ifdef IDST7_MUL_ARB_STATS_EN
      , .stat_ops(stat_ops), .stat_stalls(stat_stalls)
`endif
   );

   idst7_mul_arbiter #(.N_REQ(4), .ID_W(2), .MUL_LAT(3)) dut3 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready3),
      .req_coef(req_coef), .req_data(req_data),
      .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id3), .rsp_data(rsp_data3)
`ifdef IDST7_MUL_ARB_STATS_EN
      , .stat_ops(stat_ops3), .stat_stalls(stat_stalls3)
`endif
   );

   function automatic logic [31:0] model(input logic [6:0] c,
                                         input logic [31:0] d);
      longint p;
      p = longint'({1'b0, c}) * longint'($signed(d));
      return p[31:0];
   endfunction

   // Scoreboards: expected results are queued when a transfer is
   // seen and compared when the matching response handshakes.
   always @(negedge clk) begin
      if (reset) begin
         q1.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            checks++;
            rsp_cnt1++;
            if (q1.size() == 0) begin
               failures++;
               $display("FAIL sb1_spurious id=%0d data=%h required none",
                        rsp_id, rsp_data);
            end else begin
               e1 = q1.pop_front();
               if (rsp_id !== e1.id || rsp_data !== e1.data) begin
                  failures++;
                  $display("FAIL sb1_rsp id=%0d data=%h required id=%0d data=%h",
                           rsp_id, rsp_data, e1.id, e1.data);
               end
            end
         end
         for (int i = 0; i < 4; i++)
            if (req_valid[i] && req_ready[i])
               q1.push_back({2'(i), model(req_coef[i*7 +: 7],
                                          req_data[i*32 +: 32])});
      end
   end

   always @(negedge clk) begin
      if (reset) begin
         q3.delete();
      end else begin
         if (rsp_valid3 && rsp_ready) begin
            checks++;
            if (q3.size() == 0) begin
               failures++;
               $display("FAIL sb3_spurious id=%0d data=%h required none",
                        rsp_id3, rsp_data3);
            end else begin
               e3 = q3.pop_front();
               if (rsp_id3 !== e3.id || rsp_data3 !== e3.data) begin
                  failures++;
                  $display("FAIL sb3_rsp id=%0d data=%h required id=%0d data=%h",
                           rsp_id3, rsp_data3, e3.id, e3.data);
               end
            end
         end
         for (int i = 0; i < 4; i++)
            if (req_valid[i] && req_ready3[i])
               q3.push_back({2'(i), model(req_coef[i*7 +: 7],
                                          req_data[i*32 +: 32])});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [6:0] c,
                         input logic [31:0] d);
      req_coef[i*7 +: 7]   = c;
      req_data[i*32 +: 32] = d;
   endtask

   task automatic drain();
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int n = 0; n < 20 && (q1.size() != 0 || q3.size() != 0); n++)
         tick();
      checks++;
      if (q1.size() != 0 || q3.size() != 0) begin
         failures++;
         $display("FAIL drain_timeout q1=%0d q3=%0d required 0 0",
                  q1.size(), q3.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      req_valid = 4'hF;
      rsp_ready = 1'b1;
      req_coef = '0;
      req_data = '0;
      @(posedge clk);
      #1;
      checks++;
      if (req_ready !== 4'b0 || req_ready3 !== 4'b0) begin
         failures++;
         $display("FAIL reset_ready got=%b/%b required 0000", req_ready, req_ready3);
      end
      checks++;
      if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'd0) begin
         failures++;
         $display("FAIL reset_rsp got v=%b id=%0d d=%h required 0 0 0",
                  rsp_valid, rsp_id, rsp_data);
      end
      tick();
      reset = 1'b0;
      req_valid = '0;
   endtask

   task automatic test_single();
      set_op(0, 7'd64, -32'sd3);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL single_grant got=%b required 0001", req_ready);
      end
      tick();
      req_valid = '0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'hFFFFFF40) begin
         failures++;
         $display("FAIL single_rsp got v=%b id=%0d d=%h required 1 0 ffffff40",
                  rsp_valid, rsp_id, rsp_data);
      end
      tick();
   endtask

   task automatic test_trunc();
      set_op(2, 7'd127, 32'h7FFFFFFF);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h7FFFFF81) begin
         failures++;
         $display("FAIL trunc_max got v=%b id=%0d d=%h required 1 2 7fffff81",
                  rsp_valid, rsp_id, rsp_data);
      end
      set_op(2, 7'd0, 32'h80000000);
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h0) begin
         failures++;
         $display("FAIL trunc_zero got v=%b id=%0d d=%h required 1 2 0",
                  rsp_valid, rsp_id, rsp_data);
      end
   endtask

   task automatic test_fairness();
      logic [3:0] exp_g;
      // Pointer sits at 3 here; one grant to 3 wraps it to 0.
      req_valid = 4'b1000;
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         failures++;
         $display("FAIL fair_wrap got=%b required 1000", req_ready);
      end
      tick();
      req_valid = 4'hF;
      for (int k = 0; k < 8; k++) begin
         #1;
         exp_g = 4'b0001 << (k % 4);
         checks++;
         if (req_ready !== exp_g) begin
            failures++;
            $display("FAIL fair_all k=%0d got=%b required %b", k, req_ready, exp_g);
         end
         if (k > 0) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'((k - 1) % 4)) begin
               failures++;
               $display("FAIL fair_rsp_id k=%0d got v=%b id=%0d required 1 %0d",
                        k, rsp_valid, rsp_id, (k - 1) % 4);
            end
         end
         tick();
      end
      req_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         #1;
         exp_g = (k % 2 == 0) ? 4'b0010 : 4'b1000;
         checks++;
         if (req_ready !== exp_g) begin
            failures++;
            $display("FAIL fair_1010 k=%0d got=%b required %b", k, req_ready, exp_g);
         end
         tick();
      end
      drain();
   endtask

   task automatic test_back_to_back_stall();
      logic [31:0] e0;
      int base;
      for (int i = 0; i < 4; i++)
         set_op(i, 7'(10 + 29 * i), 32'(32'h1234_5678 * (i + 1) - 7 * i));
      e0 = model(req_coef[6:0], req_data[31:0]);
      base = rsp_cnt1;
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL bp_first got=%b required 0001", req_ready);
      end
      tick();
      rsp_ready = 1'b0;
      for (int s = 0; s < 3; s++) begin
         #1;
         checks++;
         if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== e0
             || req_ready !== 4'b0) begin
            failures++;
            $display("FAIL bp_hold s=%0d got v=%b id=%0d d=%h rdy=%b required 1 0 %h 0000",
                     s, rsp_valid, rsp_id, rsp_data, req_ready, e0);
         end
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin
         failures++;
         $display("FAIL bp_ptr_frozen got=%b required 0010", req_ready);
      end
      tick();
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
         failures++;
         $display("FAIL bp_grant2 got=%b required 0100", req_ready);
      end
      tick();
      #1;
      checks++;
      if (req_ready !== 4'b1000) begin
         failures++;
         $display("FAIL bp_grant3 got=%b required 1000", req_ready);
      end
      tick();
      drain();
      checks++;
      if (rsp_cnt1 - base != 4) begin
         failures++;
         $display("FAIL bp_count got=%0d required 4", rsp_cnt1 - base);
      end
   endtask

   task automatic test_reset_midflight();
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      tick();
      tick();
      tick();
      req_valid = '0;
      reset = 1'b1;
      #1;
      checks++;
      if (req_ready3 !== 4'b0) begin
         failures++;
         $display("FAIL rst_mid_ready got=%b required 0000", req_ready3);
      end
      tick();
      reset = 1'b0;
      for (int n = 0; n < 4; n++) begin
         #1;
         checks++;
         if (rsp_valid3 !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_flush n=%0d got=%b required 0", n, rsp_valid3);
         end
         tick();
      end
      req_valid = 4'hF;
      #1;
      checks++;
      if (req_ready3 !== 4'b0001 || req_ready !== 4'b0001) begin
         failures++;
         $display("FAIL rst_mid_grant got=%b/%b required 0001", req_ready3, req_ready);
      end
      tick();
      req_valid = '0;
      for (int n = 1; n < 3; n++) begin
         #1;
         checks++;
         if (rsp_valid3 !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_lat t+%0d got=%b required 0", n, rsp_valid3);
         end
         tick();
      end
      #1;
      checks++;
      if (rsp_valid3 !== 1'b1 || rsp_id3 !== 2'd0) begin
         failures++;
         $display("FAIL rst_mid_lat3 got v=%b id=%0d required 1 0", rsp_valid3, rsp_id3);
      end
      drain();
   endtask

`ifdef IDST7_MUL_ARB_STATS_EN
   task automatic test_stats();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (stat_ops !== 32'd0 || stat_stalls !== 32'd0) begin
         failures++;
         $display("FAIL stats_clear got=%0d/%0d required 0/0", stat_ops, stat_stalls);
      end
      rsp_ready = 1'b1;
      req_valid = 4'hF;
      for (int n = 0; n < 10; n++)
         tick();
      req_valid = '0;
      rsp_ready = 1'b0;
      for (int n = 0; n < 5; n++)
         tick();
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (stat_ops !== 32'd10 || stat_stalls !== 32'd5) begin
         failures++;
         $display("FAIL stats_count got=%0d/%0d required 10/5", stat_ops, stat_stalls);
      end
      drain();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      checks++;
      if (stat_ops !== 32'd0 || stat_stalls !== 32'd0) begin
         failures++;
         $display("FAIL stats_reset got=%0d/%0d required 0/0", stat_ops, stat_stalls);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_trunc();
      test_fairness();
      test_back_to_back_stall();
      test_reset_midflight();
`ifdef IDST7_MUL_ARB_STATS_EN
      test_stats();
`endif
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
